// File: rtl/bip3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip3_pkg
// Description : Shared types and constants for the BIP3 accumulator datapath:
//               ALU opcodes, ACC source selects, multiplier FSM states and
//               status flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package bip3_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        SEL_A_DATA = 2'b00,
        SEL_A_OPER = 2'b01,
        SEL_A_ALU  = 2'b10,
        SEL_A_MUL  = 2'b11
    } sel_a_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    // Bit positions inside the 4-bit status register {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/bip3_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : bip3_datapath_if
// Description : Control/memory bus of the BIP3 datapath. The master side is
//               the control unit plus data memory; the slave is the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface bip3_datapath_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11
);
    logic [OPERAND_WIDTH-1:0] operand_in;
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     sign_ext_in;
    logic [1:0]               sel_A_in;
    logic                     sel_B_in;
    logic [2:0]               alu_op_in;
    logic                     acc_wr_in;
    logic                     status_wr_in;
    logic                     mul_start_in;
    logic                     mul_busy_out;
    logic                     mul_done_out;
    logic [OPERAND_WIDTH-1:0] data_address_out;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     status_Z_out;
    logic                     status_N_out;
    logic                     status_C_out;
    logic                     status_V_out;

    modport master (
        output operand_in, data_in, sign_ext_in, sel_A_in, sel_B_in, alu_op_in,
               acc_wr_in, status_wr_in, mul_start_in,
        input  mul_busy_out, mul_done_out, data_address_out, data_out,
               status_Z_out, status_N_out, status_C_out, status_V_out
    );

    modport slave (
        input  operand_in, data_in, sign_ext_in, sel_A_in, sel_B_in, alu_op_in,
               acc_wr_in, status_wr_in, mul_start_in,
        output mul_busy_out, mul_done_out, data_address_out, data_out,
               status_Z_out, status_N_out, status_C_out, status_V_out
    );

endinterface
`default_nettype wire

// File: rtl/bip3_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : bip3_mul_seq
// Description : Iterative unsigned shift-add multiplier, one step per cycle,
//               DATA_WIDTH steps, low DATA_WIDTH product bits kept. Start is
//               only honoured in IDLE; done pulses for one cycle in DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module bip3_mul_seq
    import bip3_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    mul_state_t            r_state;
    mul_state_t            w_state_next;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_partial;
    logic [DATA_WIDTH-1:0] r_product;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] w_step;
    logic                  w_last;

    // Partial product after this cycle's step; bits above DATA_WIDTH are dropped
    assign w_step  = r_partial + (r_mplier[0] ? r_mcand : '0);
    assign w_last  = (r_count == CNT_W'(1));
    assign product = r_product;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= MUL_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            MUL_IDLE: if (start) w_state_next = MUL_RUN;
            MUL_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = MUL_DONE;
            end
            MUL_DONE: begin
                done         = 1'b1;
                w_state_next = MUL_IDLE;
            end
            default: w_state_next = MUL_IDLE;
        endcase
    end

    // Operand capture, shift-add steps, and product update on the final step
    // so the result is already readable during the DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_partial <= '0;
            r_product <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (start) begin
                        r_mcand   <= multiplicand;
                        r_mplier  <= multiplier;
                        r_partial <= '0;
                        r_count   <= CNT_W'(DATA_WIDTH);
                    end
                end
                MUL_RUN: begin
                    r_partial <= w_step;
                    r_mcand   <= r_mcand << 1;
                    r_mplier  <= r_mplier >> 1;
                    r_count   <= r_count - CNT_W'(1);
                    if (w_last) r_product <= w_step;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bip3_datapath.sv
`default_nettype none
// ============================================================================
// Module      : bip3_datapath
// Description : BIP3 accumulator datapath: operand extension, ACC/B muxes,
//               8-op ALU with shifts, ACC and {Z,N,C,V} status registers.
//               Optional iterative multiplier built when BIP3_MUL_EN is
//               defined; otherwise sel_A_in = 11 aliases the ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
module bip3_datapath
    import bip3_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11
) (
    input  logic clock_in,
    input  logic reset_in,
    bip3_datapath_if.slave bus
);
    localparam int MSB     = DATA_WIDTH - 1;
    localparam int SHIFT_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH:0] ONE_WIDE = (DATA_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [3:0]            r_status;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_b;
    logic [SHIFT_W-1:0]    w_shamt;
    logic [DATA_WIDTH:0]   w_sll;
    logic [DATA_WIDTH:0]   w_sra;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_c;
    logic                  w_v;
    logic [3:0]            w_flags;
    logic [DATA_WIDTH-1:0] w_acc_next;

    assign w_ext   = bus.sign_ext_in ? DATA_WIDTH'($signed(bus.operand_in))
                                     : DATA_WIDTH'(bus.operand_in);
    assign w_b     = bus.sel_B_in ? w_ext : bus.data_in;
    assign w_shamt = w_b[SHIFT_W-1:0];
    // One guard bit on the outgoing side catches the last bit shifted out
    assign w_sll   = {1'b0, r_acc} << w_shamt;
    assign w_sra   = $signed({r_acc, 1'b0}) >>> w_shamt;

    // ALU result with carry and overflow
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu_op_t'(bus.alu_op_in))
            ALU_ADD: begin
                {w_c, w_res} = {1'b0, r_acc} + {1'b0, w_b};
                w_v = (r_acc[MSB] == w_b[MSB]) && (w_res[MSB] != r_acc[MSB]);
            end
            ALU_SUB: begin
                {w_c, w_res} = {1'b0, r_acc} + {1'b0, ~w_b} + ONE_WIDE;
                w_v = (r_acc[MSB] != w_b[MSB]) && (w_res[MSB] != r_acc[MSB]);
            end
            ALU_AND: w_res = r_acc & w_b;
            ALU_OR:  w_res = r_acc | w_b;
            ALU_XOR: w_res = r_acc ^ w_b;
            ALU_NOT: w_res = ~r_acc;
            ALU_SLL: {w_c, w_res} = w_sll;
            ALU_SRA: {w_res, w_c} = w_sra;
            default: w_res = '0;
        endcase
    end

    // Flag vector; Z and N always describe the ALU result
    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_Z] = (w_res == '0);
        w_flags[FLAG_N] = w_res[MSB];
        w_flags[FLAG_C] = w_c;
        w_flags[FLAG_V] = w_v;
    end

`ifdef BIP3_MUL_EN
    logic [DATA_WIDTH-1:0] w_product;

    bip3_mul_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk          (clock_in),
        .rst          (reset_in),
        .start        (bus.mul_start_in),
        .multiplicand (r_acc),
        .multiplier   (w_b),
        .busy         (bus.mul_busy_out),
        .done         (bus.mul_done_out),
        .product      (w_product)
    );
`else
    logic w_unused_start;

    assign w_unused_start   = bus.mul_start_in;
    assign bus.mul_busy_out = 1'b0;
    assign bus.mul_done_out = 1'b0;
`endif

    // ACC source select
    always_comb begin
        w_acc_next = bus.data_in;
        case (sel_a_t'(bus.sel_A_in))
            SEL_A_DATA: w_acc_next = bus.data_in;
            SEL_A_OPER: w_acc_next = w_ext;
            SEL_A_ALU:  w_acc_next = w_res;
`ifdef BIP3_MUL_EN
            SEL_A_MUL:  w_acc_next = w_product;
`else
            SEL_A_MUL:  w_acc_next = w_res;
`endif
            default:    w_acc_next = bus.data_in;
        endcase
    end

    // ACC and status registers with independent write enables
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_acc    <= '0;
            r_status <= '0;
        end else begin
            if (bus.acc_wr_in)    r_acc    <= w_acc_next;
            if (bus.status_wr_in) r_status <= w_flags;
        end
    end

    assign bus.data_out         = r_acc;
    assign bus.data_address_out = bus.operand_in;
    assign bus.status_Z_out     = r_status[FLAG_Z];
    assign bus.status_N_out     = r_status[FLAG_N];
    assign bus.status_C_out     = r_status[FLAG_C];
    assign bus.status_V_out     = r_status[FLAG_V];

endmodule
`default_nettype wire

// File: tb/tb_bip3_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_bip3_datapath
// Description : Self-checking bench for bip3_datapath (16/11 configuration).
//               Table of ALU/ACC vectors plus multiplier handshake sequences
//               when BIP3_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip3_datapath;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bip3_datapath_if #(.DATA_WIDTH(16), .OPERAND_WIDTH(11)) bus ();

    bip3_datapath #(
        .DATA_WIDTH    (16),
        .OPERAND_WIDTH (11)
    ) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    typedef struct {
        logic [15:0] pre;
        logic [10:0] op;
        logic [15:0] data;
        logic        sx;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic [2:0]  alu;
        logic        acc_wr;
        logic        st_wr;
        logic [15:0] exp_acc;
        logic [3:0]  exp_flags;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] acc;
        logic [3:0]  flags;
    } exp_t;

    vec_t        vecs [19];
    exp_t        sb [$];
    logic [15:0] sb_mul [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {bus.status_Z_out, bus.status_N_out, bus.status_C_out, bus.status_V_out};
    endfunction

    task automatic idle_inputs();
        bus.operand_in   = '0;
        bus.data_in      = '0;
        bus.sign_ext_in  = 1'b0;
        bus.sel_A_in     = 2'b00;
        bus.sel_B_in     = 1'b0;
        bus.alu_op_in    = 3'b000;
        bus.acc_wr_in    = 1'b0;
        bus.status_wr_in = 1'b0;
        bus.mul_start_in = 1'b0;
    endtask

    task automatic load_acc(input logic [15:0] v);
        bus.data_in      = v;
        bus.sel_A_in     = 2'b00;
        bus.acc_wr_in    = 1'b1;
        bus.status_wr_in = 1'b0;
        tick();
        bus.acc_wr_in    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   done_seen;

        //              pre       op       data      sx   sA     sB   alu     aw   sw   acc       {Z,N,C,V}
        vecs[0]  = '{16'h7FFF, 11'h001, 16'h0000, 1'b0, 2'd2, 1'b1, 3'd0, 1'b1, 1'b1, 16'h8000, 4'b0101};
        vecs[1]  = '{16'h1234, 11'h7FF, 16'h0000, 1'b1, 2'd1, 1'b1, 3'd0, 1'b1, 1'b0, 16'hFFFF, 4'b0101};
        vecs[2]  = '{16'h1234, 11'h7FF, 16'h0000, 1'b0, 2'd1, 1'b1, 3'd0, 1'b1, 1'b0, 16'h07FF, 4'b0101};
        vecs[3]  = '{16'h0005, 11'h000, 16'h0005, 1'b0, 2'd2, 1'b0, 3'd1, 1'b1, 1'b1, 16'h0000, 4'b1010};
        vecs[4]  = '{16'h8001, 11'h001, 16'h0000, 1'b0, 2'd2, 1'b1, 3'd6, 1'b1, 1'b1, 16'h0002, 4'b0010};
        vecs[5]  = '{16'h0003, 11'h000, 16'h0005, 1'b0, 2'd2, 1'b0, 3'd1, 1'b1, 1'b1, 16'hFFFE, 4'b0100};
        vecs[6]  = '{16'hFFFF, 11'h000, 16'h0001, 1'b0, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 16'h0000, 4'b1010};
        vecs[7]  = '{16'h8000, 11'h001, 16'h0000, 1'b0, 2'd2, 1'b1, 3'd1, 1'b1, 1'b1, 16'h7FFF, 4'b0011};
        vecs[8]  = '{16'hF0F0, 11'h000, 16'h0FF0, 1'b0, 2'd2, 1'b0, 3'd2, 1'b1, 1'b1, 16'h00F0, 4'b0000};
        vecs[9]  = '{16'hF0F0, 11'h000, 16'h0FF0, 1'b0, 2'd2, 1'b0, 3'd3, 1'b1, 1'b1, 16'hFFF0, 4'b0100};
        vecs[10] = '{16'hF0F0, 11'h000, 16'h0FF0, 1'b0, 2'd2, 1'b0, 3'd4, 1'b1, 1'b1, 16'hFF00, 4'b0100};
        vecs[11] = '{16'h00FF, 11'h000, 16'h0000, 1'b0, 2'd2, 1'b0, 3'd5, 1'b1, 1'b1, 16'hFF00, 4'b0100};
        vecs[12] = '{16'h8018, 11'h000, 16'h0004, 1'b0, 2'd2, 1'b0, 3'd7, 1'b1, 1'b1, 16'hF801, 4'b0110};
        vecs[13] = '{16'h8018, 11'h000, 16'h0010, 1'b0, 2'd2, 1'b0, 3'd7, 1'b1, 1'b1, 16'h8018, 4'b0100};
        vecs[14] = '{16'h0003, 11'h00F, 16'h0000, 1'b0, 2'd2, 1'b1, 3'd6, 1'b1, 1'b1, 16'h8000, 4'b0110};
        vecs[15] = '{16'h0000, 11'h000, 16'h0000, 1'b0, 2'd2, 1'b0, 3'd0, 1'b0, 1'b1, 16'h0000, 4'b1000};
        vecs[16] = '{16'h0001, 11'h001, 16'h0000, 1'b0, 2'd2, 1'b1, 3'd0, 1'b1, 1'b0, 16'h0002, 4'b1000};
        vecs[17] = '{16'h1111, 11'h000, 16'hABCD, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 16'hABCD, 4'b1000};
        vecs[18] = '{16'h4000, 11'h000, 16'h4000, 1'b0, 2'd2, 1'b0, 3'd0, 1'b0, 1'b1, 16'h4000, 4'b0101};

        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        check("reset_acc",   bus.data_out, 16'h0000);
        check("reset_flags", flags(), 4'b0000);
        check("reset_busy",  bus.mul_busy_out, 1'b0);
        check("reset_done",  bus.mul_done_out, 1'b0);

        // Table-driven ALU / ACC vectors
        for (int i = 0; i < 19; i++) begin
            load_acc(vecs[i].pre);
            bus.operand_in   = vecs[i].op;
            bus.data_in      = vecs[i].data;
            bus.sign_ext_in  = vecs[i].sx;
            bus.sel_A_in     = vecs[i].sel_a;
            bus.sel_B_in     = vecs[i].sel_b;
            bus.alu_op_in    = vecs[i].alu;
            bus.acc_wr_in    = vecs[i].acc_wr;
            bus.status_wr_in = vecs[i].st_wr;
            sb.push_back('{i, vecs[i].exp_acc, vecs[i].exp_flags});
            #1;
            check($sformatf("vec%0d_addr", i), bus.data_address_out, vecs[i].op);
            tick();
            bus.acc_wr_in    = 1'b0;
            bus.status_wr_in = 1'b0;
            e = sb.pop_front();
            check($sformatf("vec%0d_acc", e.idx),   bus.data_out, e.acc);
            check($sformatf("vec%0d_flags", e.idx), flags(), e.flags);
        end

        // sel_A = 11: last product (0 since reset) or the ALU result
        load_acc(16'h0003);
        bus.operand_in = 11'h004;
        bus.sel_B_in   = 1'b1;
        bus.alu_op_in  = 3'd0;
        bus.sel_A_in   = 2'b11;
        bus.acc_wr_in  = 1'b1;
        tick();
        bus.acc_wr_in  = 1'b0;
`ifdef BIP3_MUL_EN
        check("sel_a11_product_after_reset", bus.data_out, 16'h0000);
`else
        check("sel_a11_alias_alu", bus.data_out, 16'h0007);
`endif

`ifdef BIP3_MUL_EN
        // Multiply 0x12 * 0x34 with a restart attempt and ACC write during RUN
        load_acc(16'h0012);
        bus.data_in      = 16'h0034;
        bus.sel_B_in     = 1'b0;
        bus.mul_start_in = 1'b1;
        sb_mul.push_back(16'h03A8);
        tick();
        bus.mul_start_in = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("mul_busy_c%0d", k), bus.mul_busy_out, 1'b1);
            check($sformatf("mul_done_c%0d", k), bus.mul_done_out, 1'b0);
            if (k == 2) begin
                bus.mul_start_in = 1'b1;
                bus.data_in      = 16'hFFFF;
                bus.sel_A_in     = 2'b00;
                bus.acc_wr_in    = 1'b1;
            end else begin
                bus.mul_start_in = 1'b0;
                bus.acc_wr_in    = 1'b0;
            end
            tick();
        end
        check("mul_busy_c17", bus.mul_busy_out, 1'b0);
        check("mul_done_c17", bus.mul_done_out, 1'b1);
        check("acc_write_during_run", bus.data_out, 16'hFFFF);
        bus.sel_A_in     = 2'b11;
        bus.acc_wr_in    = 1'b1;
        bus.mul_start_in = 1'b1;
        tick();
        bus.acc_wr_in    = 1'b0;
        bus.mul_start_in = 1'b0;
        check("mul_done_c18", bus.mul_done_out, 1'b0);
        check("start_in_done_ignored", bus.mul_busy_out, 1'b0);
        check("mul_product", bus.data_out, sb_mul.pop_front());

        // Reset during RUN cycle 8 aborts without a done pulse
        load_acc(16'h0003);
        bus.data_in      = 16'h0005;
        bus.sel_B_in     = 1'b0;
        bus.mul_start_in = 1'b1;
        tick();
        bus.mul_start_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("abort_busy_c%0d", k), bus.mul_busy_out, 1'b1);
            if (k == 8) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        check("abort_busy_drop", bus.mul_busy_out, 1'b0);
        check("abort_acc_cleared", bus.data_out, 16'h0000);
        check("abort_flags_cleared", flags(), 4'b0000);
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.mul_done_out || bus.mul_busy_out) done_seen++;
            tick();
        end
        check("abort_no_done", done_seen, 0);
        load_acc(16'h1234);
        bus.sel_A_in  = 2'b11;
        bus.acc_wr_in = 1'b1;
        tick();
        bus.acc_wr_in = 1'b0;
        check("abort_product_zero", bus.data_out, 16'h0000);
`else
        // Without the multiplier, start must never produce busy or done
        load_acc(16'h0012);
        bus.mul_start_in = 1'b1;
        tick();
        bus.mul_start_in = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.mul_done_out || bus.mul_busy_out) done_seen++;
            tick();
        end
        check("nomul_no_handshake", done_seen, 0);
        check("nomul_acc_kept", bus.data_out, 16'h0012);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bip3_datapath.md
# bip3_datapath

Parametrised accumulator datapath for the next BIP processor generation. It holds the accumulator, a four-flag status register, an eight-operation ALU with shifts, and an optional iterative shift-add multiplier with a start/busy/done handshake. The block sits between the control unit, which drives selects, write enables and the multiplier start, and data memory, which supplies `data_in` and consumes `data_out` and `data_address_out`.

## Interface
Parameters:
- `DATA_WIDTH`, 16: accumulator, ALU and memory data width; must be ≥ 4.
- `OPERAND_WIDTH`, 11: instruction operand and data address width; must be ≤ `DATA_WIDTH`.

Ports:
- `clock_in` input 1: the single clock; all state changes on its rising edge.
- `reset_in` input 1: reset is synchronous and active-high. It clears ACC, status and the multiplier.
- `operand_in` input `OPERAND_WIDTH`: instruction operand.
- `data_in` input `DATA_WIDTH`: memory read data.
- `sign_ext_in` input 1: 1 selects sign-extension of `operand_in`; 0 selects zero-extension.
- `sel_A_in` input 2: ACC source. 00 = `data_in`, 01 = extended operand, 10 = ALU result, 11 = multiplier product.
- `sel_B_in` input 1: ALU B operand. 1 = extended operand, 0 = `data_in`.
- `alu_op_in` input 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SLL, 111 SRA.
- `acc_wr_in` input 1: ACC write enable.
- `status_wr_in` input 1: status write enable.
- `mul_start_in` input 1: multiplier start request.
- `mul_busy_out` output 1: high while the multiplier runs.
- `mul_done_out` output 1: one-cycle completion pulse.
- `data_address_out` output `OPERAND_WIDTH`: equals `operand_in` (combinational).
- `data_out` output `DATA_WIDTH`: equals ACC.
- `status_Z_out`, `status_N_out`, `status_C_out`, `status_V_out` output 1 each: registered flags.

## Operation
- **ALU inputs.** A = ACC; B = mux(`sel_B_in`).
- **Shifts.** Shift amount is `B[$clog2(DATA_WIDTH)-1:0]`.
- **ADD.** C = carry-out. V = signed overflow.
- **SUB.** Computed as A + ~B + 1. C = 1 when there is no borrow (A ≥ B unsigned). V = signed overflow.
- **AND, OR, XOR, NOT A.** C = 0, V = 0.
- **SLL, SRA.** C = last bit shifted out; C = 0 for a zero shift. V = 0.
- **Z and N.** Z = (ALU result == 0). N = ALU result MSB. Both always come from the ALU, never from the multiplier.
- **ACC write.** On `acc_wr_in`, ACC ← mux(`sel_A_in`).
- **Status write.** On `status_wr_in`, {Z,N,C,V} ← ALU flags. The two enables are independent.
- **Multiplier.** Unsigned product, low `DATA_WIDTH` bits kept.
  - FSM states: IDLE → RUN on `mul_start_in`. At that edge, multiplicand ← ACC and multiplier ← B are captured and the counter is loaded with `DATA_WIDTH`.
  - RUN: one shift-add step per cycle. After `DATA_WIDTH` steps, go to DONE.
  - DONE: `mul_done_out` = 1 for exactly one cycle, the product register updates, then IDLE.
  - `mul_start_in` is ignored in RUN and DONE.
  - `sel_A_in` = 11 always reads the last completed product; it reads 0 after reset.
  - ACC writes during RUN do not disturb the captured operands.
- **Reset.** ACC = 0, all flags = 0, FSM = IDLE, product = 0, `mul_busy_out` = 0, `mul_done_out` = 0. Reset wins over every enable and start. Reset during RUN aborts without a done pulse.

## Timing
- ACC and status update at the edge where their enable is sampled high. The new value is visible the next cycle.
- `data_out` and `data_address_out` are combinational from ACC and `operand_in`. There is no memory-path latency.
- Multiply latency: start sampled at edge 0 → `mul_busy_out` high for cycles 1..`DATA_WIDTH` → `mul_done_out` high in cycle `DATA_WIDTH`+1.
  - The product is readable through `sel_A_in` = 11 from cycle `DATA_WIDTH`+1.
  - `mul_busy_out` is low in the DONE cycle.
  - Total for `DATA_WIDTH` = 16: 17 cycles from start to done.
- A start asserted in the same cycle as `mul_done_out` is ignored; it must be reasserted in IDLE.

## Configuration
- Macro `BIP3_MUL_EN`.
- **Defined:** the multiplier, its FSM and its handshake are built as described above.
- **Undefined:** no multiplier logic is built.
  - `mul_busy_out` and `mul_done_out` are tied to 0.
  - `mul_start_in` is ignored.
  - `sel_A_in` = 11 selects the ALU result, identical to 10.

## Structure
- Package `bip3_pkg` contains:
  - `alu_op_t` enum (3-bit, encodings above);
  - `sel_a_t` enum (2-bit);
  - `mul_state_t` enum (IDLE, RUN, DONE);
  - flag index constants for Z, N, C, V.
- Sub-module `bip3_mul_seq` holds the FSM, counter, partial product and handshake. It is instantiated only under `BIP3_MUL_EN`.
- Extension, muxes, ALU, ACC and status registers stay in `bip3_datapath`.

## Test plan
All scenarios use `DATA_WIDTH` = 16 and `OPERAND_WIDTH` = 11.
- Reset, then idle cycles → `data_out` = 0x0000, all flags 0, busy = 0, done = 0.
- Load ACC = 0x7FFF, ADD with operand 1 (`sel_B_in` = 1, zero-extended), both enables set → ACC = 0x8000, Z=0, N=1, C=0, V=1.
- `operand_in` = 0x7FF, `sel_A_in` = 01 → ACC = 0xFFFF with `sign_ext_in` = 1; ACC = 0x07FF with `sign_ext_in` = 0.
- ACC = 0x0005, SUB with B = 0x0005 → ACC = 0, Z=1, C=1. ACC = 0x8001, SLL by 1 → 0x0002, C=1.
- (`BIP3_MUL_EN`) ACC = 0x0012, B = 0x0034, start → busy for 16 cycles, done in cycle 17, `sel_A_in` = 11 → ACC = 0x03A8. A second start during RUN is ignored, and the captured operands stay unchanged by a concurrent ACC write.
- (`BIP3_MUL_EN`) Reset in RUN cycle 8 → busy drops next cycle, no done pulse, product reads 0.
